sync_multi: RTL
===============

Name: sync_multi

Overview:
- Parametrised multi-channel synchroniser for asynchronous control inputs (BBC user-port and VP415 status lines) entering the single FPGA clock domain.
- Generalises the fixed 2-flop, 1-bit synchroniser:
  - WIDTH independent channels.
  - Configurable flop-chain depth.
  - Optional per-channel glitch filter.
  - Registered single-cycle rise/fall pulses.
- Sits at the pin boundary. All downstream logic consumes sync_out, rise and fall only.

Parameters:
- WIDTH, 1, number of independent channels (>=1).
- STAGES, 2, synchroniser flops per channel before filter (>=2; <2 is an elaboration error).
- FILTER, 0, consecutive extra cycles a new level must persist before acceptance (0 = filter bypassed; <0 is an elaboration error).
- RESET_VALUE, {WIDTH{1'b0}}, per-channel level loaded into chain and sync_out on reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- async_in  input  WIDTH  asynchronous inputs, no timing relation to clk.
- sync_out  output  WIDTH  synchronised (and filtered) level.
- rise  output  WIDTH  one-cycle pulse, high in the first cycle sync_out[i] reads 1 after reading 0.
- fall  output  WIDTH  one-cycle pulse, high in the first cycle sync_out[i] reads 0 after reading 1.

Behaviour:
- One clock domain (clk). reset is synchronous and active-high.
- reset high at an edge:
  - all chain flops[i] <= RESET_VALUE[i]
  - sync_out <= RESET_VALUE
  - filter counters <= 0
  - rise, fall <= 0
  - reset dominates every other update, including a pulse due in the same cycle.
- Chain, per channel:
  - chain[0] <= async_in[i]
  - chain[k] <= chain[k-1]
  - raw[i] = chain[STAGES-1]
  - No logic between chain flops.
  - No cross-channel coherence guaranteed; channels are independent.
- Filter, per channel counter cnt, width max(1, $clog2(FILTER+1)), evaluated each non-reset edge:
  - raw == sync_out: cnt <= 0, sync_out holds.
  - raw != sync_out and cnt == FILTER: sync_out <= raw, cnt <= 0.
  - raw != sync_out and cnt < FILTER: cnt <= cnt+1, sync_out holds.
  - cnt never exceeds FILTER and never wraps.
- FILTER=0 degenerates to a plain registered output: sync_out <= raw every edge.
- Latency: an async_in level stable before edge 1 appears on sync_out after edge STAGES+1+FILTER. Defaults give 3 edges, identical to the existing 2-flop block.
- Glitch rejection:
  - A raw deviation lasting <= FILTER cycles is discarded and cnt returns to 0.
  - A deviation lasting FILTER+1 cycles is accepted.
- Edges:
  - rise[i] <= (sync_out[i] == 0) && (next sync_out[i] == 1), registered on the same edge as sync_out, so it is coincident with the new level.
  - fall is symmetric.
  - Each pulse lasts exactly one cycle; rise and fall are never both high on one channel.
  - Back-to-back toggles are possible only when FILTER=0 (rise then fall in consecutive cycles).
- After reset release, if async_in differs from RESET_VALUE, the change propagates normally and produces a rise/fall pulse after the full latency. This is intentional: no pulse suppression.
- Reset asserted mid-filter discards the partial count; the new level must requalify from 0 after release.

Test Plan:
- Defaults (WIDTH=1, STAGES=2, FILTER=0): reset, then async_in 0->1 set before edge 1 -> sync_out=1 and rise=1 after edge 3, rise=0 after edge 4; async_in 1->0 -> fall for exactly one cycle, 3 edges later.
- WIDTH=4, STAGES=3, FILTER=0: async_in 4'b0000->4'b1010 -> sync_out=4'b1010 and rise=4'b1010 after edge 4; fall=0 throughout; other channels unaffected.
- WIDTH=1, STAGES=2, FILTER=3:
  - 3-cycle high pulse -> sync_out stays 0, no rise, cnt back to 0.
  - 4-cycle pulse -> sync_out=1 after edge 2+1+3=6 from first sampled edge, rise one cycle.
  - Then 2-cycle low glitch -> sync_out stays 1.
- FILTER=3, reset asserted while cnt=2 with raw differing -> sync_out=RESET_VALUE, cnt=0, rise/fall=0; after release the level needs the full 4 qualifying cycles again.
- RESET_VALUE=1'b1, async_in held 0 through and after reset -> sync_out=1 during reset; fall pulses once at latency STAGES+1+FILTER after release; no spurious rise.
- Random async_in toggling (FILTER=0, WIDTH=8, 10k cycles) -> scoreboard: sync_out equals async_in delayed STAGES+1; rise/fall are exactly the XOR-derived edges of sync_out; never both high on one channel.

Source files
------------

// File: rtl/sync_multi.sv
// sync_multi: multi-channel synchroniser for asynchronous control inputs.
// Each channel runs through a STAGES-deep flop chain, then an optional
// persistence filter, and produces registered single-cycle rise/fall pulses
// that line up with the new level on sync_out.
module sync_multi #(
  parameter int unsigned          WIDTH       = 1,
  parameter int                   STAGES      = 2,
  parameter int                   FILTER      = 0,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_multi: STAGES must be at least 2");
  end
  if (FILTER < 0) begin : g_bad_filter
    $error("sync_multi: FILTER must not be negative");
  end

  localparam int unsigned NST     = unsigned'(STAGES);
  localparam int          CW      = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

  logic [WIDTH-1:0] chain_q [NST];
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign raw = chain_q[NST-1];

  // Filter: a differing raw level is accepted once it has been seen on
  // FILTER+1 consecutive edges; any return to the current level clears the count.
  always_comb begin
    sync_d = sync_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != sync_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sync_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Chain, filtered level, counters and edge pulses; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NST; k++) begin
        chain_q[k] <= RESET_VALUE;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      sync_q <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      chain_q[0] <= async_in;
      for (int unsigned k = 1; k < NST; k++) begin
        chain_q[k] <= chain_q[k-1];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sync_q <= sync_d;
      rise_q <= ~sync_q & sync_d;
      fall_q <= sync_q & ~sync_d;
    end
  end

  assign sync_out = sync_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule
